operand_feeder: RTL and testbench
=================================

# operand_feeder

Upstream stage for the 16-bit combinational adder unit (inputs A, B; output C = A + B, no carry-out). Accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, and drives them onto the adder's A/B one pair at a time. It waits a fixed settle interval, samples C, and returns each sum with a wrap (unsigned overflow) flag over a second valid/ready stream. It sits between the testbench/VPI stimulus side and the adder, and owns all sequencing the adder lacks.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must match the adder ports.
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- SETTLE, 1, clk cycles between driving A/B and sampling C; ≥1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock, asynchronous and active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- A  out  WIDTH  registered, to adder A.
- B  out  WIDTH  registered, to adder B.
- C  in  WIDTH  adder sum.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_sum  out  WIDTH  captured C.
- res_ovf  out  1  1 when res_sum < captured A (unsigned wrap).
- busy  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- Input transfer on edge with in_valid & in_ready: {in_a,in_b} written at FIFO tail.
- in_ready = (count < DEPTH) & ~rst. No combinational path from in_valid.
- No fall-through: a written pair is poppable no earlier than the next edge.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load A/B, cnt = SETTLE-1, go WAIT.
  - WAIT: if cnt == 0, capture res_sum = C, res_ovf = (C < A), res_valid = 1, go HOLD; else cnt--.
  - HOLD: on res_valid & res_ready, res_valid = 0. Same edge: if FIFO non-empty, pop and load A/B, go WAIT (back-to-back); else go IDLE.
- A/B keep their last value after capture; they never return to 0 except on reset.
- res_sum/res_ovf stable while res_valid = 1 and not accepted.
- Push and pop on the same edge are legal; count unchanged. Pointers wrap modulo DEPTH.
- Push when full cannot occur, since in_ready = 0.
- Arithmetic: wrap flag compares WIDTH-bit unsigned values only; no extra carry bit kept.

## Timing
- Reset values: A = 0, B = 0, res_valid = 0, res_sum = 0, res_ovf = 0, busy = 0, FIFO empty, state IDLE.
- in_ready is 0 during reset and 1 on the first edge after release.
- Reset mid-operation: FIFO flushed, in-flight pair and held result discarded immediately (asynchronous).
- Latency, idle and empty: accept at edge E0 → A/B valid after E1 → capture at E1+SETTLE → res_valid high after edge E1+SETTLE, i.e. SETTLE+1 edges after acceptance.
- Throughput with res_ready tied high: one result per SETTLE+1 cycles.
- res_ready low stalls the pipeline. The FIFO keeps filling until full, then in_ready drops.

## Structure
- Shared package opfeed_pkg:
  - state encoding IDLE/WAIT/HOLD (2 bits);
  - default WIDTH, DEPTH, SETTLE constants;
  - FIFO entry width 2*WIDTH.
- One sub-module, opfeed_fifo: synchronous FIFO, registered count, full/empty, async active-high reset.
- Top holds the FSM, settle counter, and A/B/result registers.

## Test plan
- Reset mid-HOLD with 3 entries queued → all outputs at reset values, busy = 0, in_ready = 1 after release, no stale result.
- Single pair 3+4, res_ready = 1, SETTLE = 1 → A = 3/B = 4 one edge after accept; res_valid high two edges after accept; res_sum = 7, res_ovf = 0.
- Pair 0xFFFF+0x0002 → res_sum = 0x0001, res_ovf = 1. Pair 0x8000+0x8000 → res_sum = 0, res_ovf = 1.
- res_ready held 0, push 6 pairs back-to-back (DEPTH = 4) → first pair popped; in_ready drops once count = 4. Release res_ready → results in push order, one per 2 cycles.
- Simultaneous push and pop with count = 2 → count stays 2, order preserved across pointer wrap (≥10 pairs streamed).
- SETTLE = 3, single pair 100+300 → capture 3 edges after A/B load; res_sum = 400.

Source files
------------

// File: rtl/opfeed_pkg.sv
// Shared types and defaults for the operand feeder that sequences pairs into the 16-bit adder.
package opfeed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_SETTLE = 1;

  // One FIFO entry carries {A, B}.
  function automatic int entry_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/opfeed_if.sv
// Operand stream, result stream and adder-side signals of the operand feeder.
interface opfeed_if import opfeed_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_ovf;
  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, C, res_ready,
    output in_ready, A, B, res_valid, res_sum, res_ovf, busy
  );

  modport slave (
    output in_valid, in_a, in_b, C, res_ready,
    input  in_ready, A, B, res_valid, res_sum, res_ovf, busy
  );

endinterface

// File: rtl/opfeed_fifo.sv
// Synchronous operand FIFO with registered count; a written entry is visible only after the write edge.
module opfeed_fifo import opfeed_pkg::*; #(
  parameter int DW    = entry_w(DEF_WIDTH),
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/operand_feeder.sv
// Drives buffered operand pairs onto the adder, waits SETTLE cycles, and returns sum plus wrap flag.
module operand_feeder import opfeed_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic     clk,
  input  logic     rst,
  opfeed_if.master bus
);

  localparam int EW    = entry_w(WIDTH);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic          push, pop, full, empty;
  logic [EW-1:0] head;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  assign bus.in_ready = ~full & ~rst;
  assign push         = bus.in_valid & bus.in_ready;

  opfeed_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.in_a, bus.in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = head[EW-1:WIDTH];
          b_d     = head[WIDTH-1:0];
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          sum_d   = bus.C;
          ovf_d   = (bus.C < a_q);
          vld_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          vld_d = 1'b0;
          // Back-to-back: the next pair goes out on the same edge the result is taken.
          if (!empty) begin
            pop     = 1'b1;
            a_d     = head[EW-1:WIDTH];
            b_d     = head[WIDTH-1:0];
            cnt_d   = CNT_W'(SETTLE - 1);
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.res_valid = vld_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.busy      = ~empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: directed phases with random operands, scored against a queue-based adder model.
module tb_operand_feeder;
  import opfeed_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  opfeed_if #(.WIDTH(W)) bus1 ();
  opfeed_if #(.WIDTH(W)) bus3 ();

  operand_feeder #(.WIDTH(W), .DEPTH(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  operand_feeder #(.WIDTH(W), .DEPTH(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Combinational adders under the feeders.
  assign bus1.C = bus1.A + bus1.B;
  assign bus3.C = bus3.A + bus3.B;

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_hs     = -1;
  bit   spacing_chk = 1'b0;
  bit   rand_rdy    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every accepted pair yields a 17-bit sum whose carry is the wrap flag, in arrival order.
  always @(negedge clk) begin
    if (!rst && bus1.in_valid && bus1.in_ready) begin
      logic [W:0] full_sum;
      res_t r;
      full_sum = {1'b0, bus1.in_a} + {1'b0, bus1.in_b};
      r.sum = full_sum[W-1:0];
      r.ovf = full_sum[W];
      exp_q.push_back(r);
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.res_valid && bus1.res_ready) begin
      check("result_expected", W'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        res_t r;
        r = exp_q.pop_front();
        check("res_sum", bus1.res_sum, r.sum);
        check("res_ovf", W'(bus1.res_ovf), W'(r.ovf));
      end
      if (spacing_chk && last_hs >= 0) check("result_spacing", W'(cyc - last_hs), 16'd2);
      last_hs = cyc;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus1.res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bus1.in_valid = 1'b1;
    bus1.in_a     = a;
    bus1.in_b     = b;
    forever begin
      @(negedge clk);
      if (bus1.in_ready) break;
      step();
      n++;
      if (n > 200) break;
    end
    check("push_accepted", W'(n <= 200), 16'd1);
    step();
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_remaining", W'(exp_q.size()), 16'd0);
    step();
    step();
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.res_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_a = '0; bus3.in_b = '0; bus3.res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_A", bus1.A, 16'd0);
    check("rst_B", bus1.B, 16'd0);
    check("rst_res_valid", W'(bus1.res_valid), 16'd0);
    check("rst_res_sum", bus1.res_sum, 16'd0);
    check("rst_res_ovf", W'(bus1.res_ovf), 16'd0);
    check("rst_busy", W'(bus1.busy), 16'd0);
    check("rst_in_ready", W'(bus1.in_ready), 16'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", W'(bus1.in_ready), 16'd1);
    check("post_rst_in_ready3", W'(bus3.in_ready), 16'd1);

    // Single pair 3+4, latency
    step();
    bus1.res_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_a = 16'd3; bus1.in_b = 16'd4;
    @(negedge clk);
    check("lat_in_ready", W'(bus1.in_ready), 16'd1);
    step();
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("lat_A_before_load", bus1.A, 16'd0);
    step();
    @(negedge clk);
    check("lat_A", bus1.A, 16'd3);
    check("lat_B", bus1.B, 16'd4);
    check("lat_valid_early", W'(bus1.res_valid), 16'd0);
    step();
    @(negedge clk);
    check("lat_valid", W'(bus1.res_valid), 16'd1);
    check("lat_sum", bus1.res_sum, 16'd7);
    check("lat_ovf", W'(bus1.res_ovf), 16'd0);
    step();
    drain();
    check("A_kept_after_capture", bus1.A, 16'd3);

    // Wrap cases
    push(16'hFFFF, 16'h0002);
    push(16'h8000, 16'h8000);
    drain();

    // Stall: fill FIFO behind a held result
    bus1.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(rnd_op(), rnd_op());
    @(negedge clk);
    check("full_in_ready", W'(bus1.in_ready), 16'd0);
    check("full_busy", W'(bus1.busy), 16'd1);
    check("full_res_valid", W'(bus1.res_valid), 16'd1);
    check("full_count", W'(dut1.u_fifo.count_q), 16'd4);
    step();
    bus1.in_valid = 1'b1; bus1.in_a = rnd_op(); bus1.in_b = rnd_op();
    step();
    step();
    @(negedge clk);
    check("full_blocked", W'(exp_q.size()), 16'd5);
    step();
    last_hs = -1;
    spacing_chk = 1'b1;
    bus1.res_ready = 1'b1;
    push(bus1.in_a, bus1.in_b);
    drain();
    spacing_chk = 1'b0;

    // Simultaneous push and pop at count 2, then random streaming across pointer wrap
    bus1.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(rnd_op(), rnd_op());
    @(negedge clk);
    check("pp_count_before", W'(dut1.u_fifo.count_q), 16'd2);
    check("pp_holding", W'(bus1.res_valid), 16'd1);
    step();
    bus1.in_valid = 1'b1; bus1.in_a = rnd_op(); bus1.in_b = rnd_op();
    bus1.res_ready = 1'b1;
    @(negedge clk);
    check("pp_in_ready", W'(bus1.in_ready), 16'd1);
    step();
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("pp_count_after", W'(dut1.u_fifo.count_q), 16'd2);
    step();
    rand_rdy = 1'b1;
    for (int i = 0; i < 14; i++) push(rnd_op(), rnd_op());
    rand_rdy = 1'b0;
    step();
    bus1.res_ready = 1'b1;
    drain();

    // Reset mid-HOLD with three pairs queued
    bus1.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(rnd_op(), rnd_op());
    @(negedge clk);
    check("pre_rst_hold", W'(bus1.res_valid), 16'd1);
    check("pre_rst_count", W'(dut1.u_fifo.count_q), 16'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_res_valid", W'(bus1.res_valid), 16'd0);
    check("arst_A", bus1.A, 16'd0);
    check("arst_B", bus1.B, 16'd0);
    check("arst_sum", bus1.res_sum, 16'd0);
    check("arst_busy", W'(bus1.busy), 16'd0);
    check("arst_in_ready", W'(bus1.in_ready), 16'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_in_ready", W'(bus1.in_ready), 16'd1);
    check("arst_rel_busy", W'(bus1.busy), 16'd0);
    bus1.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("arst_no_stale", W'(bus1.res_valid), 16'd0);
    end

    // SETTLE = 3 instance
    step();
    bus3.in_valid = 1'b1; bus3.in_a = 16'd100; bus3.in_b = 16'd300;
    @(negedge clk);
    check("s3_in_ready", W'(bus3.in_ready), 16'd1);
    step();
    bus3.in_valid = 1'b0;
    step();
    @(negedge clk);
    check("s3_A", bus3.A, 16'd100);
    check("s3_B", bus3.B, 16'd300);
    for (int i = 0; i < 3; i++) begin
      check("s3_not_yet", W'(bus3.res_valid), 16'd0);
      step();
      @(negedge clk);
    end
    check("s3_valid", W'(bus3.res_valid), 16'd1);
    check("s3_sum", bus3.res_sum, 16'd400);
    check("s3_ovf", W'(bus3.res_ovf), 16'd0);
    step();
    bus3.res_ready = 1'b1;
    step();
    @(negedge clk);
    check("s3_released", W'(bus3.res_valid), 16'd0);
    check("s3_idle", W'(bus3.busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
